osc_wave_engine: RTL



---
 rtl/osc_wave_engine.sv | 277 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/osc_wave_engine.sv
// Time-multiplexed oscillator output stage: phase offset/modulation, then sine/saw/square/triangle.
// Build option: define OSC_PWM_EN for a per-oscillator pulse-width register (otherwise 50% square).
module osc_wave_engine #(
  parameter int unsigned VOICES    = 8,
  parameter int unsigned V_OSC     = 4,
  parameter int unsigned V_WIDTH   = 3,
  parameter int unsigned O_WIDTH   = 2,
  parameter int unsigned PH_WIDTH  = 11,
  parameter int unsigned OUT_WIDTH = 17
) (
  input  logic                 sCLK_XVXOSC,
  input  logic                 iRST_N,
  input  logic                 osc_sel,
  input  logic [6:0]           reg_adr,
  input  logic                 reg_wr,
  input  logic [7:0]           reg_wdata,
  input  logic                 reg_rd,
  output logic [7:0]           reg_rdata,
  output logic                 rd_valid,
  input  logic                 in_valid,
  input  logic [V_WIDTH-1:0]   in_vx,
  input  logic [O_WIDTH-1:0]   in_ox,
  input  logic [PH_WIDTH-1:0]  phase_acc,
  input  logic [PH_WIDTH-1:0]  modulation,
  output logic                 out_valid,
  output logic [V_WIDTH-1:0]   out_vx,
  output logic [O_WIDTH-1:0]   out_ox,
  output logic [OUT_WIDTH-1:0] wave_out
);

  localparam int unsigned OFF_SH = PH_WIDTH - 8;
  localparam int unsigned SAW_SH = OUT_WIDTH - PH_WIDTH;
  localparam int unsigned TRI_SH = OUT_WIDTH - PH_WIDTH + 1;
  localparam int unsigned SIN_SH = OUT_WIDTH - 17;
  localparam logic [PH_WIDTH-1:0] PH_HALF    = PH_WIDTH'(1) << (PH_WIDTH - 1);
  localparam logic [PH_WIDTH-1:0] PH_QUARTER = PH_WIDTH'(1) << (PH_WIDTH - 2);
  localparam logic signed [OUT_WIDTH-1:0] POS_M = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [OUT_WIDTH-1:0] NEG_M = {1'b1, {(OUT_WIDTH-2){1'b0}}, 1'b1};

  if (PH_WIDTH < 11 || OUT_WIDTH < 17 || OUT_WIDTH < PH_WIDTH || V_OSC > 8 ||
      (1 << V_WIDTH) < VOICES || (1 << O_WIDTH) < V_OSC) begin : g_param_check
    $error("osc_wave_engine: unsupported parameter combination");
  end

  // Centred sine table: parabolic half-wave per half period, full scale +/-65535.
  function automatic logic signed [16:0] sine_lookup(input logic [10:0] adr);
    logic [10:0] p;
    logic [10:0] pc;
    logic [20:0] q;
    logic [34:0] prod;
    logic [16:0] mag;
    p    = {1'b0, adr[9:0]};
    pc   = 11'd1024 - p;
    q    = 21'(p) * 21'(pc);
    prod = 35'(q) * 35'(65535);
    mag  = 17'(prod >> 18);
    sine_lookup = adr[10] ? -$signed(mag) : $signed(mag);
  endfunction

  // Patch registers
  logic [7:0] off_q [V_OSC];
  logic [1:0] ws_q  [V_OSC];
`ifdef OSC_PWM_EN
  logic [7:0] pw_q  [V_OSC];
`endif
  logic [7:0] rdata_q;
  logic       rd_valid_q;
  logic [7:0] rd_mux;
  logic [2:0] adr_osc;
  logic [3:0] adr_lo;

  assign adr_osc = reg_adr[6:4];
  assign adr_lo  = reg_adr[3:0];

  always_comb begin
    rd_mux = 8'h00;
    for (int i = 0; i < int'(V_OSC); i++) begin
      if (adr_osc == 3'(i)) begin
        case (adr_lo)
          4'd6: rd_mux = off_q[i];
          4'd7: rd_mux = {6'b0, ws_q[i]};
`ifdef OSC_PWM_EN
          4'd8: rd_mux = pw_q[i];
`endif
          default: rd_mux = 8'h00;
        endcase
      end
    end
  end

  always_ff @(posedge sCLK_XVXOSC or negedge iRST_N) begin
    if (!iRST_N) begin
      for (int i = 0; i < int'(V_OSC); i++) begin
        off_q[i] <= 8'h00;
        ws_q[i]  <= 2'd0;
`ifdef OSC_PWM_EN
        pw_q[i]  <= 8'h80;
`endif
      end
    end else if (reg_wr && osc_sel) begin
      for (int i = 0; i < int'(V_OSC); i++) begin
        if (adr_osc == 3'(i)) begin
          if (adr_lo == 4'd6) off_q[i] <= reg_wdata;
          if (adr_lo == 4'd7) ws_q[i]  <= reg_wdata[1:0];
`ifdef OSC_PWM_EN
          if (adr_lo == 4'd8) pw_q[i]  <= reg_wdata;
`endif
        end
      end
    end
  end

  // Read port samples the pre-write value, so a same-cycle write is not visible
  always_ff @(posedge sCLK_XVXOSC or negedge iRST_N) begin
    if (!iRST_N) begin
      rdata_q    <= 8'h00;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= reg_rd && osc_sel;
      if (reg_rd && osc_sel) rdata_q <= rd_mux;
    end
  end

  assign reg_rdata = rdata_q;
  assign rd_valid  = rd_valid_q;

  // Stage 1: capture slot and fetch its patch settings
  logic [7:0]          fetch_off;
  logic [1:0]          fetch_ws;
  logic                s1_v_q;
  logic [V_WIDTH-1:0]  s1_vx_q;
  logic [O_WIDTH-1:0]  s1_ox_q;
  logic [PH_WIDTH-1:0] s1_ph_q;
  logic [PH_WIDTH-1:0] s1_mod_q;
  logic [7:0]          s1_off_q;
  logic [1:0]          s1_ws_q;
`ifdef OSC_PWM_EN
  logic [7:0]          fetch_pw;
  logic [7:0]          s1_pw_q;
  logic [7:0]          s2_pw_q;
`endif

  always_comb begin
    fetch_off = 8'h00;
    fetch_ws  = 2'd0;
`ifdef OSC_PWM_EN
    fetch_pw  = 8'h80;
`endif
    for (int i = 0; i < int'(V_OSC); i++) begin
      if (in_ox == O_WIDTH'(i)) begin
        fetch_off = off_q[i];
        fetch_ws  = ws_q[i];
`ifdef OSC_PWM_EN
        fetch_pw  = pw_q[i];
`endif
      end
    end
  end

  always_ff @(posedge sCLK_XVXOSC or negedge iRST_N) begin
    if (!iRST_N) begin
      s1_v_q   <= 1'b0;
      s1_vx_q  <= '0;
      s1_ox_q  <= '0;
      s1_ph_q  <= '0;
      s1_mod_q <= '0;
      s1_off_q <= 8'h00;
      s1_ws_q  <= 2'd0;
`ifdef OSC_PWM_EN
      s1_pw_q  <= 8'h80;
`endif
    end else begin
      s1_v_q <= in_valid;
      if (in_valid) begin
        s1_vx_q  <= in_vx;
        s1_ox_q  <= in_ox;
        s1_ph_q  <= phase_acc;
        s1_mod_q <= modulation;
        s1_off_q <= fetch_off;
        s1_ws_q  <= fetch_ws;
`ifdef OSC_PWM_EN
        s1_pw_q  <= fetch_pw;
`endif
      end
    end
  end

  // Stage 2: effective phase, wrapping modulo 2^PH_WIDTH
  logic [PH_WIDTH-1:0] off_ext;
  logic [PH_WIDTH-1:0] s2_u_d;
  logic                s2_v_q;
  logic [V_WIDTH-1:0]  s2_vx_q;
  logic [O_WIDTH-1:0]  s2_ox_q;
  logic [PH_WIDTH-1:0] s2_u_q;
  logic [1:0]          s2_ws_q;

  assign off_ext = {{(PH_WIDTH-8){s1_off_q[7]}}, s1_off_q};
  assign s2_u_d  = s1_ph_q + s1_mod_q + (off_ext << OFF_SH);

  always_ff @(posedge sCLK_XVXOSC or negedge iRST_N) begin
    if (!iRST_N) begin
      s2_v_q  <= 1'b0;
      s2_vx_q <= '0;
      s2_ox_q <= '0;
      s2_u_q  <= '0;
      s2_ws_q <= 2'd0;
`ifdef OSC_PWM_EN
      s2_pw_q <= 8'h80;
`endif
    end else begin
      s2_v_q <= s1_v_q;
      if (s1_v_q) begin
        s2_vx_q <= s1_vx_q;
        s2_ox_q <= s1_ox_q;
        s2_u_q  <= s2_u_d;
        s2_ws_q <= s1_ws_q;
`ifdef OSC_PWM_EN
        s2_pw_q <= s1_pw_q;
`endif
      end
    end
  end

  // Stage 3: waveform generation
  logic [PH_WIDTH-1:0]         thr;
  logic [PH_WIDTH-1:0]         fold;
  logic signed [PH_WIDTH-1:0]  saw_c;
  logic signed [PH_WIDTH-1:0]  tri_c;
  logic signed [16:0]          sin_c;
  logic signed [OUT_WIDTH-1:0] wave_d;
  logic                        out_v_q;
  logic [V_WIDTH-1:0]          out_vx_q;
  logic [O_WIDTH-1:0]          out_ox_q;
  logic [OUT_WIDTH-1:0]        wave_q;

  always_comb begin
`ifdef OSC_PWM_EN
    thr = {s2_pw_q, {(PH_WIDTH-8){1'b0}}};
`else
    thr = PH_HALF;
`endif
    saw_c = $signed({~s2_u_q[PH_WIDTH-1], s2_u_q[PH_WIDTH-2:0]});
    fold  = s2_u_q[PH_WIDTH-1] ? ~s2_u_q : s2_u_q;
    tri_c = $signed(fold - PH_QUARTER);
    sin_c = sine_lookup(s2_u_q[PH_WIDTH-1 -: 11]);
    wave_d = '0;
    case (s2_ws_q)
      2'd0: wave_d = OUT_WIDTH'(sin_c) <<< SIN_SH;
      2'd1: wave_d = OUT_WIDTH'(saw_c) <<< SAW_SH;
      2'd2: wave_d = (s2_u_q < thr) ? POS_M : NEG_M;
      2'd3: wave_d = OUT_WIDTH'(tri_c) <<< TRI_SH;
      default: wave_d = '0;
    endcase
  end

  always_ff @(posedge sCLK_XVXOSC or negedge iRST_N) begin
    if (!iRST_N) begin
      out_v_q  <= 1'b0;
      out_vx_q <= '0;
      out_ox_q <= '0;
      wave_q   <= '0;
    end else begin
      out_v_q <= s2_v_q;
      if (s2_v_q) begin
        out_vx_q <= s2_vx_q;
        out_ox_q <= s2_ox_q;
        wave_q   <= wave_d;
      end
    end
  end

  assign out_valid = out_v_q;
  assign out_vx    = out_vx_q;
  assign out_ox    = out_ox_q;
  assign wave_out  = wave_q;

endmodule
